vga_rx_monitor: RTL and testbench

Receive-side checker for the VGA output. It samples hs/vs/r/g/b as they leave vgac, recovers column/row counters from the sync edges, and measures line and frame timing against 640x480@60 parameters. It also declares lock, flags timing errors, and captures one programmable pixel per frame. It sits in benches and on-chip debug logic beside vgac, on the same vga_clk.

---
 rtl/vga_rx_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_monitor.sv
// Receive-side VGA timing monitor: recovers column/row from hs/vs, checks line and frame timing,
// declares lock and captures one selectable pixel per frame. Define FRAME_SUM_EN to add a per-frame pixel sum.
module vga_rx_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int H_START     = 144,
    parameter int V_START     = 35,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic        hs,
    input  logic        vs,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    input  logic [9:0]  cap_x,
    input  logic [9:0]  cap_y,
    input  logic        clr_err,
    output logic        locked,
    output logic [9:0]  rx_col,
    output logic [9:0]  rx_row,
    output logic        in_active,
    output logic [9:0]  h_total,
    output logic [9:0]  v_total,
    output logic [15:0] frame_cnt,
    output logic        err_h,
    output logic        err_v,
    output logic [11:0] cap_rgb,
    output logic        cap_valid,
    output logic [15:0] frame_sum
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t      state, state_nxt;
    logic [3:0]  good_frames, good_nxt;
    logic        locked_nxt, frame_inc;
    logic        hs_d, vs_d;
    logic        hs_fall, hs_rise, vs_fall, vs_rise;
    logic [9:0]  h_cnt, v_cnt, hs_width, vs_width;
    logic        frame_err;
    logic        checks_on, h_fail, v_fail, frame_ok;
    logic        h_in, v_in, cap_hit;

    assign hs_fall = hs_d & ~hs;
    assign hs_rise = ~hs_d & hs;
    assign vs_fall = vs_d & ~vs;
    assign vs_rise = ~vs_d & vs;

    assign checks_on = (state != SEARCH);

    // A missing hs is caught on the step into 1023, so the saturated counter does not re-fire.
    assign h_fail = checks_on &&
        ((hs_fall && ((11'(h_cnt) + 11'd1) != 11'(H_TOTAL))) ||
         (hs_rise && (hs_width != 10'(H_SYNC))) ||
         (!hs_fall && (h_cnt == 10'd1022)));

    assign v_fail = checks_on &&
        ((vs_fall && ((11'(v_cnt) + 11'd1) != 11'(V_TOTAL))) ||
         (vs_rise && (vs_width != 10'(V_SYNC))) ||
         (hs_fall && !vs_fall && ((11'(v_cnt) + 11'd1) == 11'(V_TOTAL))));

    assign frame_ok = !frame_err && !h_fail && !v_fail;

    assign h_in = (11'(h_cnt) >= 11'(H_START)) && (11'(h_cnt) < 11'(H_START + H_ACTIVE));
    assign v_in = (11'(v_cnt) >= 11'(V_START)) && (11'(v_cnt) < 11'(V_START + V_ACTIVE));

    assign cap_hit = locked && in_active && (rx_col == cap_x) && (rx_row == cap_y);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            hs_d        <= 1'b0;
            vs_d        <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            hs_width    <= '0;
            vs_width    <= '0;
            h_total     <= '0;
            v_total     <= '0;
            err_h       <= 1'b0;
            err_v       <= 1'b0;
            frame_err   <= 1'b0;
            state       <= SEARCH;
            good_frames <= '0;
            locked      <= 1'b0;
            frame_cnt   <= '0;
            in_active   <= 1'b0;
            rx_col      <= '0;
            rx_row      <= '0;
            cap_rgb     <= '0;
            cap_valid   <= 1'b0;
        end else begin
            hs_d <= hs;
            vs_d <= vs;

            if (hs_fall) begin
                h_cnt   <= '0;
                h_total <= h_cnt + 10'd1;
            end else if (h_cnt != 10'h3FF) begin
                h_cnt <= h_cnt + 10'd1;
            end

            if (hs_fall)                          hs_width <= 10'd1;
            else if (!hs && hs_width != 10'h3FF)  hs_width <= hs_width + 10'd1;

            // vs_fall takes priority over the hs_fall that normally accompanies it.
            if (vs_fall) begin
                v_cnt   <= '0;
                v_total <= v_cnt + 10'd1;
            end else if (hs_fall && v_cnt != 10'h3FF) begin
                v_cnt <= v_cnt + 10'd1;
            end

            if (vs_fall)                                    vs_width <= {9'd0, hs_fall};
            else if (!vs && hs_fall && vs_width != 10'h3FF) vs_width <= vs_width + 10'd1;

            if (h_fail)       err_h <= 1'b1;
            else if (clr_err) err_h <= 1'b0;
            if (v_fail)       err_v <= 1'b1;
            else if (clr_err) err_v <= 1'b0;

            if (vs_fall)               frame_err <= 1'b0;
            else if (h_fail || v_fail) frame_err <= 1'b1;

            state       <= state_nxt;
            good_frames <= good_nxt;
            locked      <= locked_nxt;
            if (frame_inc) frame_cnt <= frame_cnt + 16'd1;

            in_active <= h_in && v_in;
            rx_col    <= (h_in && v_in) ? h_cnt - 10'(H_START) : '0;
            rx_row    <= (h_in && v_in) ? v_cnt - 10'(V_START) : '0;

            cap_valid <= cap_hit;
            if (cap_hit) cap_rgb <= {r, g, b};
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        good_nxt   = good_frames;
        locked_nxt = locked;
        frame_inc  = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_nxt = MEASURE;
                    good_nxt  = '0;
                end
            end
            MEASURE: begin
                if (vs_fall) begin
                    if (!frame_ok) begin
                        good_nxt = '0;
                    end else if ((good_frames + 4'd1) == 4'(LOCK_FRAMES)) begin
                        good_nxt   = good_frames + 4'd1;
                        state_nxt  = LOCKED;
                        locked_nxt = 1'b1;
                    end else begin
                        good_nxt = good_frames + 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (h_fail || v_fail) begin
                    state_nxt  = SEARCH;
                    locked_nxt = 1'b0;
                    good_nxt   = '0;
                end else if (vs_fall) begin
                    frame_inc = 1'b1;
                end
            end
            default: begin
                state_nxt  = SEARCH;
                locked_nxt = 1'b0;
                good_nxt   = '0;
            end
        endcase
    end

`ifdef FRAME_SUM_EN
    logic [15:0] sum_acc;

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            sum_acc   <= '0;
            frame_sum <= '0;
        end else if (vs_fall) begin
            frame_sum <= sum_acc;
            sum_acc   <= '0;
        end else if (in_active) begin
            sum_acc <= sum_acc + 16'({r, g, b});
        end
    end
`else
    assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a reduced raster (40x20 clocks/lines) so a frame is 800 cycles.
module tb_vga_rx_monitor;

    localparam int HT = 40, HS = 4, VT = 20, VS = 2;
    localparam int HST = 8, VST = 3, HA = 24, VA = 12, LF = 2;
    localparam int FRAME  = HT * VT;
    localparam int BUDGET = 3 * FRAME;
    // A pixel of column c is presented at line position c+HST+2 (two register stages before in_active).
    localparam int PIX_OFS = HST + 2;

    logic        vga_clk, clrn, hs, vs, clr_err;
    logic [3:0]  r, g, b;
    logic [9:0]  cap_x, cap_y;
    logic        locked, in_active, err_h, err_v, cap_valid;
    logic [9:0]  rx_col, rx_row, h_total, v_total;
    logic [15:0] frame_cnt, frame_sum;
    logic [11:0] cap_rgb;

    vga_rx_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .V_SYNC(VS),
        .H_START(HST), .V_START(VST), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
    ) dut (
        .vga_clk(vga_clk), .clrn(clrn), .hs(hs), .vs(vs),
        .r(r), .g(g), .b(b), .cap_x(cap_x), .cap_y(cap_y), .clr_err(clr_err),
        .locked(locked), .rx_col(rx_col), .rx_row(rx_row), .in_active(in_active),
        .h_total(h_total), .v_total(v_total), .frame_cnt(frame_cnt),
        .err_h(err_h), .err_v(err_v), .cap_rgb(cap_rgb), .cap_valid(cap_valid),
        .frame_sum(frame_sum)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int errors = 0;
    int checks = 0;

    bit          gen_on = 1'b0;
    bit          stretch_req = 1'b0, kill_req = 1'b0;
    bit          stretch_now, kill_now;
    int          pat = 0;
    int          line_len;
    int          clocked_line = -1, clocked_pos = -1;
    int          cap_pulses = 0;
    logic [11:0] cap_seen = '0;

    function automatic logic [11:0] pixel(input int line, input int p, input int pt);
        int c, rr;
        logic [3:0] nib;
        c  = p - PIX_OFS;
        rr = line - VST;
        if (c < 0 || c >= HA || rr < 0 || rr >= VA) return 12'h000;
        nib = c[3:0];
        case (pt)
            0:       return 12'hFFF;
            1:       return {nib, nib, nib};
            default: return 12'h001;
        endcase
    endfunction

    // Video source: hs low for the first HS clocks of each line, vs low for the first VS lines.
    initial begin
        hs = 1'b1;
        vs = 1'b1;
        {r, g, b} = 12'h000;
        wait (gen_on);
        @(posedge vga_clk);
        #1;
        forever begin
            stretch_now = stretch_req;
            stretch_req = 1'b0;
            kill_now    = kill_req;
            kill_req    = 1'b0;
            for (int l = 0; l < VT; l++) begin
                line_len = (stretch_now && l == 5) ? HT + 1 : HT;
                for (int p = 0; p < line_len; p++) begin
                    hs = (p >= HS);
                    vs = !(l < VS && !kill_now);
                    {r, g, b} = pixel(l, p, pat);
                    @(posedge vga_clk);
                    clocked_line = l;
                    clocked_pos  = p;
                    #1;
                end
            end
        end
    end

    always @(negedge vga_clk) begin
        if (cap_valid === 1'b1) begin
            cap_pulses = cap_pulses + 1;
            cap_seen   = cap_rgb;
        end
    end

    // Returns 2 time units after the edge that clocked sample (l,p).
    task automatic wait_clocked(input int l, input int p, input string tag);
        int n;
        n = 0;
        do begin
            @(posedge vga_clk);
            #2;
            n++;
        end while (!(clocked_line == l && clocked_pos == p) && n < BUDGET);
        if (!(clocked_line == l && clocked_pos == p)) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for line %0d pos %0d", tag, l, p);
        end
    endtask

    task automatic test_reset();
        clrn = 1'b1; clr_err = 1'b0; cap_x = '0; cap_y = '0;
        #1 clrn = 1'b0;
        #100;
        checks++;
        if ({locked, in_active, err_h, err_v, cap_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {locked, in_active, err_h, err_v, cap_valid});
        end
        checks++;
        if ({rx_col, rx_row, h_total, v_total} !== 40'd0) begin
            errors++; $display("FAIL reset_counts: got %h expected 0", {rx_col, rx_row, h_total, v_total});
        end
        checks++;
        if ({frame_cnt, cap_rgb, frame_sum} !== 44'd0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {frame_cnt, cap_rgb, frame_sum});
        end
        @(negedge vga_clk);
        clrn = 1'b1;
        repeat (3) @(posedge vga_clk);
        gen_on = 1'b1;
    endtask

    task automatic test_lock();
        wait_clocked(0, 0, "lock_vsf1");
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL lock_vsf1: locked=%b expected 0", locked); end
        wait_clocked(0, 0, "lock_vsf2");
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL lock_vsf2: locked=%b expected 0", locked); end
        wait_clocked(0, 0, "lock_vsf3");
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL lock_vsf3: locked=%b expected 1", locked); end
        checks++;
        if (h_total !== 10'(HT)) begin errors++; $display("FAIL h_total: got %0d expected %0d", h_total, HT); end
        checks++;
        if (v_total !== 10'(VT)) begin errors++; $display("FAIL v_total: got %0d expected %0d", v_total, VT); end
        checks++;
        if ({err_h, err_v} !== 2'b00) begin errors++; $display("FAIL lock_errs: got %b expected 00", {err_h, err_v}); end
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL lock_frame_cnt: got %0d expected 0", frame_cnt); end
    endtask

    task automatic test_active_window();
        wait_clocked(VST + 2, HST, "win_left_out");
        checks++;
        if ({in_active, rx_col} !== 11'd0) begin
            errors++; $display("FAIL win_left_out: in_active=%b rx_col=%0d expected 0/0", in_active, rx_col);
        end
        wait_clocked(VST + 2, HST + 6, "win_mid");
        checks++;
        if ({in_active, rx_col, rx_row} !== {1'b1, 10'd5, 10'd2}) begin
            errors++; $display("FAIL win_mid: in_active=%b col=%0d row=%0d expected 1/5/2", in_active, rx_col, rx_row);
        end
        wait_clocked(VST + 2, HST + HA, "win_right_edge");
        checks++;
        if ({in_active, rx_col} !== {1'b1, 10'(HA - 1)}) begin
            errors++; $display("FAIL win_right_edge: in_active=%b col=%0d expected 1/%0d", in_active, rx_col, HA - 1);
        end
        wait_clocked(VST + 2, HST + HA + 1, "win_right_out");
        checks++;
        if (in_active !== 1'b0) begin errors++; $display("FAIL win_right_out: in_active=%b expected 0", in_active); end
        wait_clocked(VST + VA, HST + 6, "win_bottom_out");
        checks++;
        if ({in_active, rx_row} !== 11'd0) begin
            errors++; $display("FAIL win_bottom_out: in_active=%b row=%0d expected 0/0", in_active, rx_row);
        end
        wait_clocked(0, 0, "win_vsf");
        checks++;
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL frame_cnt_1: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_capture();
        int          xs[3] = '{0, HA - 1, 10};
        int          ys[3] = '{0, VA - 1, 4};
        int          col;
        logic [3:0]  nib;
        logic [11:0] exp;
        pat = 1;
        for (int i = 0; i < 3; i++) begin
            cap_x = 10'(xs[i]);
            cap_y = 10'(ys[i]);
            col = xs[i];
            nib = col[3:0];
            exp = {nib, nib, nib};
            cap_pulses = 0;
            wait_clocked(0, 0, "cap_vsf");
            checks++;
            if (cap_pulses !== 1) begin
                errors++; $display("FAIL cap_pulses(%0d,%0d): got %0d expected 1", xs[i], ys[i], cap_pulses);
            end
            checks++;
            if (cap_seen !== exp) begin
                errors++; $display("FAIL cap_rgb(%0d,%0d): got %h expected %h", xs[i], ys[i], cap_seen, exp);
            end
        end
        checks++;
        if (frame_cnt !== 16'd4) begin errors++; $display("FAIL frame_cnt_4: got %0d expected 4", frame_cnt); end
    endtask

    task automatic test_stretch();
        stretch_req = 1'b1;
        wait_clocked(5, HT, "stretch_extra");
        checks++;
        if ({locked, frame_cnt} !== {1'b1, 16'd5}) begin
            errors++; $display("FAIL stretch_pre: locked=%b frame_cnt=%0d expected 1/5", locked, frame_cnt);
        end
        wait_clocked(6, 0, "stretch_hs_fall");
        checks++;
        if ({err_h, err_v, locked} !== 3'b100) begin
            errors++; $display("FAIL stretch_err: err_h/err_v/locked=%b expected 100", {err_h, err_v, locked});
        end
        for (int i = 1; i <= 3; i++) begin
            wait_clocked(0, 0, "stretch_relock");
            checks++;
            if (locked !== (i == 3)) begin
                errors++; $display("FAIL stretch_relock_%0d: locked=%b expected %0d", i, locked, (i == 3));
            end
        end
        checks++;
        if ({err_h, frame_cnt} !== {1'b1, 16'd5}) begin
            errors++; $display("FAIL stretch_sticky: err_h=%b frame_cnt=%0d expected 1/5", err_h, frame_cnt);
        end
        clr_err = 1'b1;
        @(posedge vga_clk);
        #2;
        clr_err = 1'b0;
        checks++;
        if (err_h !== 1'b0) begin errors++; $display("FAIL clr_err: err_h=%b expected 0", err_h); end
    endtask

    task automatic test_vs_missing();
        kill_req = 1'b1;
        wait_clocked(0, 0, "vs_missing");
        checks++;
        if ({err_v, err_h, locked} !== 3'b100) begin
            errors++; $display("FAIL vs_missing: err_v/err_h/locked=%b expected 100", {err_v, err_h, locked});
        end
        for (int i = 1; i <= 3; i++) begin
            wait_clocked(0, 0, "vs_relock");
            checks++;
            if (locked !== (i == 3)) begin
                errors++; $display("FAIL vs_relock_%0d: locked=%b expected %0d", i, locked, (i == 3));
            end
        end
    endtask

    task automatic test_midframe_reset();
        wait_clocked(VST + 2, HST + 5, "mid_reset_point");
        checks++;
        if ({locked, in_active} !== 2'b11) begin
            errors++; $display("FAIL mid_reset_pre: locked/in_active=%b expected 11", {locked, in_active});
        end
        #1 clrn = 1'b0;
        #1;
        checks++;
        if ({locked, in_active, err_h, err_v, cap_valid, rx_col, rx_row} !== 25'd0) begin
            errors++; $display("FAIL mid_reset_flags: got %h expected 0", {locked, in_active, err_h, err_v, cap_valid, rx_col, rx_row});
        end
        checks++;
        if ({frame_cnt, cap_rgb, h_total, v_total, frame_sum} !== 64'd0) begin
            errors++; $display("FAIL mid_reset_data: got %h expected 0", {frame_cnt, cap_rgb, h_total, v_total, frame_sum});
        end
        @(negedge vga_clk);
        clrn = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wait_clocked(0, 0, "reset_relock");
            checks++;
            if (locked !== (i == 3)) begin
                errors++; $display("FAIL reset_relock_%0d: locked=%b expected %0d", i, locked, (i == 3));
            end
        end
    endtask

    task automatic test_frame_sum();
        int          pats[2] = '{2, 0};
        int          vals[2] = '{1, 4095};
        logic [15:0] exp;
        for (int i = 0; i < 2; i++) begin
            pat = pats[i];
`ifdef FRAME_SUM_EN
            exp = 16'((vals[i] * HA * VA) % 65536);
`else
            exp = 16'(vals[i] * 0);
`endif
            wait_clocked(0, 0, "sum_vsf");
            checks++;
            if (frame_sum !== exp) begin
                errors++; $display("FAIL frame_sum_%0d: got %h expected %h", i, frame_sum, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_active_window();
        test_capture();
        test_stretch();
        test_vs_missing();
        test_midframe_reset();
        test_frame_sum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
